amb_hakem: RTL and testbench
============================

Name: amb_hakem

Overview:
- Round-robin arbiter and sequencer that shares the core's single combinational ALU (amb) between N requesters, e.g. the execute stage and the address/branch-compare unit.
- Accepts one operation at a time over a valid/ready handshake, registers the operands, and drives the ALU ports for one cycle.
- Captures the ALU result and returns it to the owning requester over a second valid/ready handshake.

Parameters:
- N, default 2: number of requesters; supported range 2..4.
- IDW, default 1: width of the owner index; must equal clog2(N).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- istek_i  input  N  request valid, one bit per requester.
- kabul_o  output  N  request accepted (ready), one-hot or zero.
- secim_i  input  N  per-requester operand-B select (1 = immediate).
- fonksiyon_i  input  4*N  per-requester function code; requester k uses bits [4k+3:4k].
- reg_a_i  input  32*N  per-requester rs1 value.
- reg_b_i  input  32*N  per-requester rs2 value.
- sabit_i  input  32*N  per-requester immediate value.
- sonuc_gecerli_o  output  N  result valid; one-hot or zero.
- sonuc_hazir_i  input  N  requester ready to take its result.
- sonuc_o  output  32  result word, shared by all requesters.
- sonuc_hata_o  output  1  result carries an invalid function code.
- amb_secim_o, amb_fonksiyon_o (4), amb_reg_a_o (32), amb_reg_b_o (32), amb_sabit_o (32)  output  ALU drive.
- amb_cikis_i  input  32  ALU result.

Behaviour:
- States: BOS (idle), ISLEM (ALU evaluating), SONUC (result held).
- Reset (async): state=BOS; oncelik=0; sahip=0; all operand registers, sonuc_o and sonuc_hata_o = 0; kabul_o=0; sonuc_gecerli_o=0. ALU drive ports therefore read 0.
- BOS, grant selection:
  - Grant the first requester with istek_i set, scanning from index oncelik upward and wrapping modulo N.
  - kabul_o[g] is combinational and asserted only in BOS, only for the granted g.
  - If no istek_i bit is set, kabul_o=0 and the block stays in BOS.
- BOS, on istek_i[g] & kabul_o[g] at an edge:
  - Latch secim, fonksiyon, reg_a, reg_b and sabit of requester g into the operand registers.
  - Set sahip=g and move to ISLEM.
- ALU drive ports always show the operand registers. They are stable for the whole ISLEM cycle and hold their last values otherwise.
- ISLEM, at the next edge:
  - If fonksiyon <= 4'b0100: sonuc_o = amb_cikis_i and sonuc_hata_o = 0.
  - Otherwise: sonuc_o = 0 and sonuc_hata_o = 1. The ALU output is x in this case and must never propagate.
  - Move to SONUC.
- SONUC:
  - sonuc_gecerli_o[sahip]=1; sonuc_o and sonuc_hata_o are held stable.
  - On sonuc_hazir_i[sahip]: oncelik=(sahip+1) mod N, then move to BOS. sonuc_gecerli_o drops in the BOS cycle.
  - sonuc_hazir_i bits of non-owners are ignored.
- Latency: accept edge E, result visible after edge E+1, earliest retire at edge E+2. Minimum 3 cycles per operation; no new kabul_o while in ISLEM or SONUC.
- Boundary conditions:
  - Simultaneous requests: exactly one grant per BOS cycle. After requester k retires, k has the lowest priority.
  - Starvation-free: a continuously requesting requester is granted within N operations.
  - istek_i may drop before acceptance with no effect. Requesters must hold operands stable while istek_i is high and unaccepted.
  - A requester whose result is not taken stalls the arbiter indefinitely. This is intended backpressure.
  - Reset mid-operation discards the in-flight operation; no result is delivered.

Decomposition:
- Shared package amb_paket holds:
  - function codes AMB_TOPLA=4'b0000, AMB_CIKAR=4'b0001, AMB_VE=4'b0010, AMB_XOR=4'b0011, AMB_VEYA=4'b0100;
  - AMB_SON_GECERLI=4'b0100, the highest valid code;
  - the hakem_durum_t enum {BOS, ISLEM, SONUC}.
- One sub-module, amb_oncelik_secici: combinational rotating-priority selector.
  - Inputs: istek (N), oncelik (IDW).
  - Outputs: one-hot grant (N), grant index (IDW), gecerli.

Test Plan:
- Single op: requester 0, fonksiyon 0000, a=5, b=7, secim=0; sonuc_hazir held 1 → kabul_o=01 for one cycle, sonuc_gecerli_o=01 two cycles later, sonuc_o=12, sonuc_hata_o=0.
- Immediate path: requester 1, fonksiyon 0001, a=10, sabit=3, secim=1 → amb_secim_o=1 during ISLEM, sonuc_o=7.
- Contention: both request continuously from reset with ADD 1+1 (req0) and XOR F0^0F (req1) → grants alternate 0,1,0,1; results 2, FF, 2, FF.
- Backpressure: req0 op completes with sonuc_hazir_i=0 for 5 cycles while req1 requests → sonuc_o stable, kabul_o=0 throughout, req1 granted the cycle after retirement.
- Invalid code: fonksiyon 0111 with ALU model driving x → sonuc_o=0, sonuc_hata_o=1, no x on any output.
- Reset in ISLEM: assert rst_i during ISLEM → all outputs 0 immediately, no sonuc_gecerli_o pulse, next request granted normally from oncelik=0.

Source files
------------

// File: rtl/amb_paket.sv
// Shared definitions for the ALU arbiter/sequencer.
// Function codes, FSM states and the operand bundle.
package amb_paket;

  localparam logic [3:0] AMB_TOPLA = 4'b0000;
  localparam logic [3:0] AMB_CIKAR = 4'b0001;
  localparam logic [3:0] AMB_VE    = 4'b0010;
  localparam logic [3:0] AMB_XOR   = 4'b0011;
  localparam logic [3:0] AMB_VEYA  = 4'b0100;

  // Highest function code the ALU defines.
  localparam logic [3:0] AMB_SON_GECERLI = 4'b0100;

  typedef enum logic [1:0] {
    BOS,
    ISLEM,
    SONUC
  } hakem_durum_t;

  // One registered ALU operation.
  typedef struct packed {
    logic        secim;
    logic [3:0]  fonksiyon;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] sabit;
  } islem_t;

  function automatic logic kod_gecerli(
    input logic [3:0] f
  );
    return f <= AMB_SON_GECERLI;
  endfunction

endpackage

// File: rtl/amb_oncelik_secici.sv
// Rotating-priority selector: first set request
// at or above oncelik, wrapping modulo N.
module amb_oncelik_secici
  import amb_paket::*;
#(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   istek,
  input  logic [IDW-1:0] oncelik,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] indeks,
  output logic           gecerli
);

  logic [IDW-1:0] aday;

  // Scan from the priority pointer; first hit wins.
  always_comb begin
    grant   = '0;
    indeks  = '0;
    gecerli = 1'b0;
    aday    = '0;
    for (int i = 0; i < N; i++) begin
      aday = IDW'((int'(oncelik) + i) % N);
      if (!gecerli && istek[aday]) begin
        gecerli     = 1'b1;
        indeks      = aday;
        grant[aday] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amb_hakem.sv
// Round-robin arbiter sharing one combinational
// ALU between N requesters, one op at a time.
module amb_hakem
  import amb_paket::*;
#(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    istek_i,
  output logic [N-1:0]    kabul_o,
  input  logic [N-1:0]    secim_i,
  input  logic [4*N-1:0]  fonksiyon_i,
  input  logic [32*N-1:0] reg_a_i,
  input  logic [32*N-1:0] reg_b_i,
  input  logic [32*N-1:0] sabit_i,
  output logic [N-1:0]    sonuc_gecerli_o,
  input  logic [N-1:0]    sonuc_hazir_i,
  output logic [31:0]     sonuc_o,
  output logic            sonuc_hata_o,
  output logic            amb_secim_o,
  output logic [3:0]      amb_fonksiyon_o,
  output logic [31:0]     amb_reg_a_o,
  output logic [31:0]     amb_reg_b_o,
  output logic [31:0]     amb_sabit_o,
  input  logic [31:0]     amb_cikis_i
);

  hakem_durum_t   durum, durum_n;
  logic [IDW-1:0] oncelik;
  logic [IDW-1:0] sahip;
  islem_t         islem;
  logic [31:0]    sonuc;
  logic           hata;

  logic [N-1:0]   grant;
  logic [IDW-1:0] indeks;
  logic           gecerli;
  logic           kabul_et;
  logic           teslim;

  logic [3:0]     fonk_d [N];
  logic [31:0]    a_d    [N];
  logic [31:0]    b_d    [N];
  logic [31:0]    s_d    [N];

  for (genvar k = 0; k < N; k++) begin : g_ayir
    assign fonk_d[k] = fonksiyon_i[4*k +: 4];
    assign a_d[k]    = reg_a_i[32*k +: 32];
    assign b_d[k]    = reg_b_i[32*k +: 32];
    assign s_d[k]    = sabit_i[32*k +: 32];
  end

  amb_oncelik_secici #(
    .N   (N),
    .IDW (IDW)
  ) u_secici (
    .istek   (istek_i),
    .oncelik (oncelik),
    .grant   (grant),
    .indeks  (indeks),
    .gecerli (gecerli)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum <= BOS;
    else       durum <= durum_n;
  end

  // Next state, handshake outputs and strobes.
  always_comb begin
    durum_n         = durum;
    kabul_o         = '0;
    sonuc_gecerli_o = '0;
    kabul_et        = 1'b0;
    teslim          = 1'b0;
    unique case (durum)
      BOS: begin
        if (!rst_i) kabul_o = grant;
        if (gecerli && !rst_i) begin
          kabul_et = 1'b1;
          durum_n  = ISLEM;
        end
      end
      ISLEM: durum_n = SONUC;
      SONUC: begin
        sonuc_gecerli_o[sahip] = 1'b1;
        if (sonuc_hazir_i[sahip]) begin
          teslim  = 1'b1;
          durum_n = BOS;
        end
      end
      default: durum_n = BOS;
    endcase
  end

  // Capture the granted requester's operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      islem <= '0;
      sahip <= '0;
    end else if (kabul_et) begin
      islem <= '{
        secim:     secim_i[indeks],
        fonksiyon: fonk_d[indeks],
        reg_a:     a_d[indeks],
        reg_b:     b_d[indeks],
        sabit:     s_d[indeks]
      };
      sahip <= indeks;
    end
  end

  // Rotate priority past the owner on retirement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       oncelik <= '0;
    else if (teslim) oncelik <= IDW'((int'(sahip) + 1) % N);
  end

  // Sample the ALU; unknown codes never pass its x.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sonuc <= '0;
      hata  <= 1'b0;
    end else if (durum == ISLEM) begin
      if (kod_gecerli(islem.fonksiyon)) begin
        sonuc <= amb_cikis_i;
        hata  <= 1'b0;
      end else begin
        sonuc <= '0;
        hata  <= 1'b1;
      end
    end
  end

  assign sonuc_o         = sonuc;
  assign sonuc_hata_o    = hata;
  assign amb_secim_o     = islem.secim;
  assign amb_fonksiyon_o = islem.fonksiyon;
  assign amb_reg_a_o     = islem.reg_a;
  assign amb_reg_b_o     = islem.reg_b;
  assign amb_sabit_o     = islem.sabit;

endmodule

// File: tb/tb_amb_hakem.sv
// Directed bench for amb_hakem with a transaction
// model and per-cycle output comparison.
module tb_amb_hakem;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    istek;
  logic [N-1:0]    kabul;
  logic [N-1:0]    secim;
  logic [4*N-1:0]  fonk;
  logic [32*N-1:0] ra, rb, imm;
  logic [N-1:0]    gec;
  logic [N-1:0]    hazir;
  logic [31:0]     sonuc;
  logic            hata;
  logic            a_sec;
  logic [3:0]      a_fonk;
  logic [31:0]     a_ra, a_rb, a_imm, a_cikis;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  amb_hakem #(.N(N), .IDW(IDW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .istek_i         (istek),
    .kabul_o         (kabul),
    .secim_i         (secim),
    .fonksiyon_i     (fonk),
    .reg_a_i         (ra),
    .reg_b_i         (rb),
    .sabit_i         (imm),
    .sonuc_gecerli_o (gec),
    .sonuc_hazir_i   (hazir),
    .sonuc_o         (sonuc),
    .sonuc_hata_o    (hata),
    .amb_secim_o     (a_sec),
    .amb_fonksiyon_o (a_fonk),
    .amb_reg_a_o     (a_ra),
    .amb_reg_b_o     (a_rb),
    .amb_sabit_o     (a_imm),
    .amb_cikis_i     (a_cikis)
  );

  function automatic logic [31:0] alu_ref(
    input logic [3:0]  f,
    input logic [31:0] x,
    input logic [31:0] y
  );
    case (f)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x ^ y;
      default: return x | y;
    endcase
  endfunction

  // ALU stand-in: undefined codes produce x.
  always_comb begin
    if (a_fonk <= 4'd4)
      a_cikis = alu_ref(a_fonk, a_ra,
                        a_sec ? a_imm : a_rb);
    else
      a_cikis = 'x;
  end

  function automatic int pick(
    input logic [N-1:0] r,
    input int           p
  );
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction model: idle / evaluating / holding.
  int          m_ph   = 0;
  int          m_own  = 0;
  int          m_prio = 0;
  int          m_g;
  logic        m_sec  = 1'b0;
  logic [3:0]  m_f    = '0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;
  logic [31:0] m_i    = '0;
  logic [31:0] m_res  = '0;
  logic        m_err  = 1'b0;

  always_comb m_g = pick(istek, m_prio);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_own <= 0; m_prio <= 0;
      m_sec <= 1'b0; m_f <= '0;
      m_a <= '0; m_b <= '0; m_i <= '0;
      m_res <= '0; m_err <= 1'b0;
    end else begin
      case (m_ph)
        0: if (m_g >= 0) begin
          m_own <= m_g;
          m_sec <= secim[m_g];
          m_f   <= fonk[4*m_g +: 4];
          m_a   <= ra[32*m_g +: 32];
          m_b   <= rb[32*m_g +: 32];
          m_i   <= imm[32*m_g +: 32];
          m_ph  <= 1;
        end
        1: begin
          if (m_f <= 4'd4) begin
            m_res <= alu_ref(m_f, m_a,
                             m_sec ? m_i : m_b);
            m_err <= 1'b0;
          end else begin
            m_res <= '0;
            m_err <= 1'b1;
          end
          m_ph <= 2;
        end
        default: if (hazir[m_own]) begin
          m_prio <= (m_own + 1) % N;
          m_ph   <= 0;
        end
      endcase
    end
  end

  // Observed-event logs for literal checks.
  int          acc_q[$];
  int          ret_own[$];
  logic [31:0] ret_res[$];
  logic        ret_err[$];
  int          cyc = 0, acc_cyc = 0;
  int          val_cyc = 0, ret_cyc = 0;
  int          n_gec = 0;
  logic        gec_d = 1'b0;
  logic [N-1:0] ek, eg;

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    ek = '0;
    eg = '0;
    if (!rst && m_ph == 0 && m_g >= 0)
      ek = N'(1) << m_g;
    if (m_ph == 2) eg = N'(1) << m_own;
    chk("kabul",    32'(kabul), 32'(ek));
    chk("gecerli",  32'(gec),   32'(eg));
    chk("sonuc",    sonuc,      m_res);
    chk("hata",     32'(hata),  32'(m_err));
    chk("amb_secim", 32'(a_sec), 32'(m_sec));
    chk("amb_fonk", 32'(a_fonk), 32'(m_f));
    chk("amb_a",    a_ra,  m_a);
    chk("amb_b",    a_rb,  m_b);
    chk("amb_sabit", a_imm, m_i);
    if (|(kabul & istek)) begin
      acc_q.push_back(oh2i(kabul));
      acc_cyc = cyc;
    end
    if (|gec) n_gec++;
    if (|gec && !gec_d) val_cyc = cyc;
    gec_d = |gec;
    if (|(gec & hazir)) begin
      ret_own.push_back(oh2i(gec));
      ret_res.push_back(sonuc);
      ret_err.push_back(hata);
      ret_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(
    input int          k,
    input logic [3:0]  f,
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] i
  );
    fonk[4*k +: 4]  = f;
    secim[k]        = s;
    ra[32*k +: 32]  = a;
    rb[32*k +: 32]  = b;
    imm[32*k +: 32] = i;
  endtask

  task automatic wait_acc(input int n);
    for (int c = 0; c < 30; c++) begin
      if (acc_q.size() >= n) return;
      tick();
    end
    chk("acc_timeout", acc_q.size(), n);
  endtask

  task automatic wait_ret(input int n);
    for (int c = 0; c < 30; c++) begin
      if (ret_res.size() >= n) return;
      tick();
    end
    chk("ret_timeout", ret_res.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t",
             $time);
    $fatal(1);
  end

  int ab, rb0, ng;

  initial begin
    istek = '0; hazir = '0; secim = '0;
    fonk  = '0; ra = '0; rb = '0; imm = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_sonuc", sonuc, 0);
    chk("rst_gec", 32'(gec), 0);
    chk("rst_kabul", 32'(kabul), 0);
    chk("rst_amb_a", a_ra, 0);
    tick();
    rst = 1'b0;

    // Single ADD on requester 0.
    hazir = 2'b11;
    set_op(0, 4'b0000, 1'b0, 5, 7, 0);
    istek[0] = 1'b1;
    wait_acc(1);
    istek[0] = 1'b0;
    wait_ret(1);
    chk("t1_grant", acc_q[0], 0);
    chk("t1_own", ret_own[0], 0);
    chk("t1_res", ret_res[0], 12);
    chk("t1_err", 32'(ret_err[0]), 0);
    chk("t1_lat", val_cyc - acc_cyc, 2);

    // Immediate operand on requester 1.
    set_op(1, 4'b0001, 1'b1, 10, 99, 3);
    istek[1] = 1'b1;
    wait_acc(2);
    istek[1] = 1'b0;
    chk("t2_amb_sec", 32'(a_sec), 1);
    chk("t2_amb_fonk", 32'(a_fonk), 1);
    wait_ret(2);
    chk("t2_own", ret_own[1], 1);
    chk("t2_res", ret_res[1], 7);

    // Contention from reset.
    ab  = acc_q.size();
    rb0 = ret_res.size();
    set_op(0, 4'b0000, 1'b0, 1, 1, 0);
    set_op(1, 4'b0011, 1'b0, 32'hF0, 32'h0F, 0);
    istek = 2'b11;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    wait_ret(rb0 + 4);
    istek = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant", acc_q[ab + i], i % 2);
      chk("t3_res", ret_res[rb0 + i],
          (i % 2) ? 32'hFF : 32'h2);
    end

    // Backpressure on requester 0.
    hazir = 2'b00;
    ab  = acc_q.size();
    rb0 = ret_res.size();
    set_op(0, 4'b0000, 1'b0, 3, 4, 0);
    set_op(1, 4'b0010, 1'b0, 32'hFF, 32'h0F, 0);
    istek = 2'b11;
    wait_acc(ab + 1);
    istek[0] = 1'b0;
    chk("t4_first", acc_q[ab], 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_kabul", 32'(kabul), 0);
      chk("t4_sonuc", sonuc, 7);
      chk("t4_gec", 32'(gec), 32'b01);
      tick();
    end
    hazir = 2'b11;
    wait_acc(ab + 2);
    istek[1] = 1'b0;
    chk("t4_second", acc_q[ab + 1], 1);
    chk("t4_gap", acc_cyc - ret_cyc, 1);
    wait_ret(rb0 + 2);
    chk("t4_res0", ret_res[rb0], 7);
    chk("t4_res1", ret_res[rb0 + 1], 32'h0F);

    // Undefined function code.
    rb0 = ret_res.size();
    set_op(0, 4'b0111, 1'b0,
           32'h1234, 32'h5678, 0);
    istek[0] = 1'b1;
    wait_acc(acc_q.size() + 1);
    istek[0] = 1'b0;
    wait_ret(rb0 + 1);
    chk("t5_res", ret_res[rb0], 0);
    chk("t5_err", 32'(ret_err[rb0]), 1);

    // Reset while evaluating.
    rb0 = ret_res.size();
    set_op(1, 4'b0000, 1'b0, 1, 2, 0);
    istek[1] = 1'b1;
    wait_acc(acc_q.size() + 1);
    rst   = 1'b1;
    istek = '0;
    #1;
    chk("t6_sonuc", sonuc, 0);
    chk("t6_hata", 32'(hata), 0);
    chk("t6_gec", 32'(gec), 0);
    chk("t6_amb_a", a_ra, 0);
    ng = n_gec;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_nopulse", n_gec, ng);
    chk("t6_noret", ret_res.size(), rb0);
    set_op(0, 4'b0000, 1'b0, 20, 22, 0);
    ab = acc_q.size();
    istek = 2'b11;
    wait_acc(ab + 1);
    istek = '0;
    chk("t6_grant", acc_q[ab], 0);
    wait_ret(rb0 + 1);
    chk("t6_res", ret_res[rb0], 42);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
